// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage load/store path: funct3 width codes,
// FSM state encoding, the latched-transaction payload and the alignment check
// used by the optional misalignment trap (MISALIGN_TRAP_EN).
package mem_pkg;

    localparam int DMEM_BE_WIDTH = 4;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQ       = 2'd1,
        ST_WAIT_RESP = 2'd2
    } state_t;

    // Instruction fields held while a memory transaction is in flight
    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic        reg_write;
        logic        m2reg;
        logic        is_store;
    } pend_t;

    // Halfword accesses need addr[0]=0, word accesses need addr[1:0]=0
    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [1:0] addr_lo,
                                           input logic       store);
        logic half;
        logic word;
        half = store ? (f3 == F3_SH) : (f3 == F3_LH || f3 == F3_LHU);
        word = store ? (f3 == F3_SW) : (f3 == F3_LW);
        return (half && addr_lo[0]) || (word && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_stage_store_align.sv
// Store lane steering: replicates store data across byte lanes and derives
// byte enables from funct3 and the low address bits. Purely combinational so
// a future cache path can share it.
module store_align
    import mem_pkg::*;
(
    input  logic [2:0]               funct3,
    input  logic [1:0]               addr_lo,
    input  logic [31:0]              store_data,
    output logic [31:0]              wdata,
    output logic [DMEM_BE_WIDTH-1:0] be
);

    // Width decode; unknown widths write nothing but still issue a request
    always_comb begin
        wdata = store_data;
        be    = '0;
        case (funct3)
            F3_SB: begin
                wdata = {4{store_data[7:0]}};
                be    = 4'b0001 << addr_lo;
            end
            F3_SH: begin
                wdata = {2{store_data[15:0]}};
                be    = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            F3_SW: begin
                wdata = store_data;
                be    = 4'b1111;
            end
            default: begin
                wdata = store_data;
                be    = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit. Accepts one op per handshake in IDLE, issues a
// word-aligned data-memory request for loads/stores, and registers the MEM/WB
// payload with a one-cycle wb_valid pulse. Accesses that run too long are
// abandoned with wb_bus_err. Define MISALIGN_TRAP_EN to trap misaligned
// half/word accesses instead of issuing them.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ex_valid,
    output logic                     ex_ready,
    input  logic [31:0]              ex_alu_result,
    input  logic [31:0]              ex_store_data,
    input  logic [2:0]               ex_funct3,
    input  logic                     ex_mem_read,
    input  logic                     ex_mem_write,
    input  logic                     ex_m2reg,
    input  logic [4:0]               ex_rd,
    input  logic                     ex_reg_write,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic [31:0]              dmem_addr,
    output logic [31:0]              dmem_wdata,
    output logic [DMEM_BE_WIDTH-1:0] dmem_be,
    input  logic                     dmem_ready,
    input  logic                     dmem_rvalid,
    input  logic [31:0]              dmem_rdata,
    output logic                     wb_valid,
    output logic [31:0]              wb_address,
    output logic [31:0]              wb_rdata,
    output logic                     wb_m2reg,
    output logic [2:0]               wb_funct3,
    output logic [4:0]               wb_rd,
    output logic                     wb_reg_write,
    output logic                     wb_bus_err,
    output logic                     wb_misalign
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                   st;
    state_t                   st_nxt;
    logic [CNT_W-1:0]         cnt;
    pend_t                    pend;
    logic [31:0]              req_wdata;
    logic [DMEM_BE_WIDTH-1:0] req_be;
    logic [31:0]              al_wdata;
    logic [DMEM_BE_WIDTH-1:0] al_be;
    logic                     is_mem;
    logic                     trap;
    logic                     accept;
    logic                     done_ok;
    logic                     timeout;

    store_align u_align (
        .funct3     (ex_funct3),
        .addr_lo    (ex_alu_result[1:0]),
        .store_data (ex_store_data),
        .wdata      (al_wdata),
        .be         (al_be)
    );

    assign is_mem = ex_mem_read | ex_mem_write;
`ifdef MISALIGN_TRAP_EN
    assign trap = is_mem && is_misaligned(ex_funct3, ex_alu_result[1:0], ex_mem_write);
`else
    assign trap = 1'b0;
`endif
    assign accept = (st == ST_IDLE) && ex_valid;

    // Request outputs come from the latched copy so they stay stable in REQ
    assign dmem_we    = dmem_req & pend.is_store;
    assign dmem_addr  = dmem_req ? {pend.addr[31:2], 2'b00} : 32'h0;
    assign dmem_wdata = dmem_req ? req_wdata : 32'h0;
    assign dmem_be    = dmem_req ? req_be : '0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) st <= ST_IDLE;
        else     st <= st_nxt;
    end

    // Next state and handshake; completion takes priority over timeout
    always_comb begin
        st_nxt   = st;
        ex_ready = 1'b0;
        dmem_req = 1'b0;
        done_ok  = 1'b0;
        timeout  = 1'b0;
        case (st)
            ST_IDLE: begin
                ex_ready = 1'b1;
                if (ex_valid && is_mem && !trap) st_nxt = ST_REQ;
            end
            ST_REQ: begin
                dmem_req = 1'b1;
                if (dmem_ready && (pend.is_store || dmem_rvalid)) begin
                    done_ok = 1'b1;
                    st_nxt  = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    timeout = 1'b1;
                    st_nxt  = ST_IDLE;
                end else if (dmem_ready) begin
                    st_nxt = ST_WAIT_RESP;
                end
            end
            ST_WAIT_RESP: begin
                if (dmem_rvalid) begin
                    done_ok = 1'b1;
                    st_nxt  = ST_IDLE;
                end else if (cnt == CNT_LAST) begin
                    timeout = 1'b1;
                    st_nxt  = ST_IDLE;
                end
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    // Cycles spent in REQ+WAIT_RESP; zero on the first REQ cycle
    always_ff @(posedge clk) begin
        if (rst || st == ST_IDLE || st_nxt == ST_IDLE) cnt <= '0;
        else                                           cnt <= cnt + 1'b1;
    end

    // Latch the accepted memory op; loads carry no byte enables
    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= '0;
            req_wdata <= '0;
            req_be    <= '0;
        end else if (accept && is_mem && !trap) begin
            pend.addr      <= ex_alu_result;
            pend.funct3    <= ex_funct3;
            pend.rd        <= ex_rd;
            pend.reg_write <= ex_reg_write;
            pend.m2reg     <= ex_m2reg;
            pend.is_store  <= ex_mem_write;
            req_wdata      <= ex_mem_write ? al_wdata : 32'h0;
            req_be         <= ex_mem_write ? al_be : '0;
        end
    end

    // MEM/WB register: pulse wb_valid on direct completion, memory completion or timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            wb_address   <= '0;
            wb_rdata     <= '0;
            wb_m2reg     <= 1'b0;
            wb_funct3    <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            wb_bus_err   <= 1'b0;
            wb_misalign  <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            if (accept && (!is_mem || trap)) begin
                wb_valid     <= 1'b1;
                wb_address   <= ex_alu_result;
                wb_rdata     <= 32'h0;
                wb_m2reg     <= ex_m2reg;
                wb_funct3    <= ex_funct3;
                wb_rd        <= ex_rd;
                wb_reg_write <= ex_reg_write & ~trap;
                wb_bus_err   <= 1'b0;
                wb_misalign  <= trap;
            end else if (done_ok || timeout) begin
                wb_valid     <= 1'b1;
                wb_address   <= pend.addr;
                wb_rdata     <= (done_ok && !pend.is_store) ? dmem_rdata : 32'h0;
                wb_m2reg     <= pend.m2reg;
                wb_funct3    <= pend.funct3;
                wb_rd        <= pend.rd;
                wb_reg_write <= pend.reg_write & ~timeout;
                wb_bus_err   <= timeout;
                wb_misalign  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: ALU pass-through, store lane steering,
// load with wait states, timeout, reset mid-transaction and misaligned access
// (follows MISALIGN_TRAP_EN like the design).
module tb_mem_access_stage;

    localparam int TO = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic [2:0]  ex_funct3;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_m2reg;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_address;
    logic [31:0] wb_rdata;
    logic        wb_m2reg;
    logic [2:0]  wb_funct3;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        wb_bus_err;
    logic        wb_misalign;

    int errors = 0;
    int checks = 0;

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_funct3(ex_funct3), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_m2reg(ex_m2reg), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_address(wb_address), .wb_rdata(wb_rdata),
        .wb_m2reg(wb_m2reg), .wb_funct3(wb_funct3), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .wb_bus_err(wb_bus_err), .wb_misalign(wb_misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; everything is driven and sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op, let it be accepted on the next edge, then drop ex_valid
    task automatic issue(input logic [31:0] a, input logic [31:0] sd, input logic [2:0] f3,
                         input logic rd_en, input logic wr_en, input logic m2r,
                         input logic [4:0] rdn, input logic rw);
        ex_valid      = 1'b1;
        ex_alu_result = a;
        ex_store_data = sd;
        ex_funct3     = f3;
        ex_mem_read   = rd_en;
        ex_mem_write  = wr_en;
        ex_m2reg      = m2r;
        ex_rd         = rdn;
        ex_reg_write  = rw;
        chk("accept_ready", ex_ready, 1);
        tick();
        ex_valid     = 1'b0;
        ex_mem_read  = 1'b0;
        ex_mem_write = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ex_valid = 0; ex_alu_result = 0; ex_store_data = 0; ex_funct3 = 0;
        ex_mem_read = 0; ex_mem_write = 0; ex_m2reg = 0; ex_rd = 0; ex_reg_write = 0;
        dmem_ready = 0; dmem_rvalid = 0; dmem_rdata = 0;
        tick(); tick();
        chk("rst_ex_ready", ex_ready, 1);
        chk("rst_req", dmem_req, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_addr", wb_address, 0);
        chk("rst_be", dmem_be, 0);
        rst = 1'b0;

        // ALU op, latency 1
        issue(32'h55, 0, 3'b000, 0, 0, 0, 5'd5, 1);
        chk("alu_wb_valid", wb_valid, 1);
        chk("alu_wb_addr", wb_address, 32'h55);
        chk("alu_wb_rdata", wb_rdata, 0);
        chk("alu_wb_rd", wb_rd, 5);
        chk("alu_wb_rw", wb_reg_write, 1);
        chk("alu_req", dmem_req, 0);
        tick();
        chk("alu_pulse_end", wb_valid, 0);

        // Ten back-to-back ALU ops
        for (int i = 0; i < 10; i++) begin
            ex_valid = 1; ex_alu_result = 32'h100 + i; ex_rd = 5'(i);
            tick();
            chk("b2b_valid", wb_valid, 1);
            chk("b2b_addr", wb_address, 32'h100 + i);
            chk("b2b_req", dmem_req, 0);
        end
        ex_valid = 0;
        tick();
        chk("b2b_end", wb_valid, 0);

        // Idle rvalid is ignored
        dmem_rvalid = 1; dmem_rdata = 32'h0BAD0BAD;
        tick();
        chk("idle_rvalid", wb_valid, 0);
        dmem_rvalid = 0;

        // SB to 0x1003, ready on the first REQ cycle
        issue(32'h1003, 32'h000000A5, 3'b000, 0, 1, 0, 5'd0, 0);
        chk("sb_req", dmem_req, 1);
        chk("sb_we", dmem_we, 1);
        chk("sb_addr", dmem_addr, 32'h1000);
        chk("sb_be", dmem_be, 4'b1000);
        chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
        chk("sb_busy", ex_ready, 0);
        chk("sb_no_wb", wb_valid, 0);
        dmem_ready = 1;
        tick();
        dmem_ready = 0;
        chk("sb_wb_valid", wb_valid, 1);
        chk("sb_wb_addr", wb_address, 32'h1003);
        chk("sb_wb_rdata", wb_rdata, 0);
        chk("sb_idle", ex_ready, 1);
        chk("sb_req_drop", dmem_req, 0);

        // SH to 0x2002, one stall cycle, request must hold
        issue(32'h2002, 32'h1234ABCD, 3'b001, 0, 1, 0, 5'd0, 0);
        tick();
        chk("sh_hold_req", dmem_req, 1);
        chk("sh_hold_addr", dmem_addr, 32'h2000);
        chk("sh_be", dmem_be, 4'b1100);
        chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
        dmem_ready = 1;
        tick();
        dmem_ready = 0;
        chk("sh_wb_valid", wb_valid, 1);

        // SW and an unknown-width store (no bytes written, still completes)
        issue(32'h4000, 32'h11223344, 3'b010, 0, 1, 0, 5'd0, 0);
        chk("sw_be", dmem_be, 4'b1111);
        chk("sw_wdata", dmem_wdata, 32'h11223344);
        dmem_ready = 1;
        tick();
        dmem_ready = 0;
        chk("sw_wb_valid", wb_valid, 1);
        issue(32'h4004, 32'h55667788, 3'b011, 0, 1, 0, 5'd0, 0);
        chk("sx_be", dmem_be, 4'b0000);
        chk("sx_we", dmem_we, 1);
        dmem_ready = 1;
        tick();
        dmem_ready = 0;
        chk("sx_wb_valid", wb_valid, 1);

        // LW 0x2000: ready in 3rd REQ cycle, rvalid 2 cycles later
        issue(32'h2000, 0, 3'b010, 1, 0, 1, 5'd7, 1);
        chk("lw_we", dmem_we, 0);
        chk("lw_be", dmem_be, 0);
        chk("lw_addr", dmem_addr, 32'h2000);
        tick();
        chk("lw_busy1", ex_ready, 0);
        tick();
        chk("lw_busy2", ex_ready, 0);
        dmem_ready = 1;
        tick();
        dmem_ready = 0;
        chk("lw_wait_req", dmem_req, 0);
        chk("lw_busy3", ex_ready, 0);
        tick();
        chk("lw_busy4", ex_ready, 0);
        chk("lw_no_wb", wb_valid, 0);
        dmem_rvalid = 1; dmem_rdata = 32'hDEADBEEF;
        tick();
        dmem_rvalid = 0;
        chk("lw_wb_valid", wb_valid, 1);
        chk("lw_wb_rdata", wb_rdata, 32'hDEADBEEF);
        chk("lw_wb_addr", wb_address, 32'h2000);
        chk("lw_wb_m2reg", wb_m2reg, 1);
        chk("lw_wb_rd", wb_rd, 7);
        chk("lw_wb_rw", wb_reg_write, 1);
        chk("lw_wb_f3", wb_funct3, 3'b010);
        chk("lw_wb_err", wb_bus_err, 0);

        // LBU: rvalid without ready ignored, then ready+rvalid together
        issue(32'h10, 0, 3'b100, 1, 0, 1, 5'd9, 1);
        dmem_rvalid = 1; dmem_rdata = 32'hBADBAD00;
        tick();
        chk("lbu_ignored", wb_valid, 0);
        chk("lbu_still_req", dmem_req, 1);
        dmem_ready = 1; dmem_rdata = 32'h12345678;
        tick();
        dmem_ready = 0; dmem_rvalid = 0;
        chk("lbu_wb_valid", wb_valid, 1);
        chk("lbu_wb_rdata", wb_rdata, 32'h12345678);

        // Timeout: load whose request is never accepted
        issue(32'h5000, 0, 3'b010, 1, 0, 1, 5'd4, 1);
        chk("to_req", dmem_req, 1);
        for (int k = 0; k < TO - 1; k++) begin
            tick();
            chk("to_pending", wb_valid, 0);
        end
        tick();
        chk("to_wb_valid", wb_valid, 1);
        chk("to_bus_err", wb_bus_err, 1);
        chk("to_rw", wb_reg_write, 0);
        chk("to_idle", ex_ready, 1);
        chk("to_req_drop", dmem_req, 0);

        // Reset while in WAIT_RESP, then a stray rvalid
        issue(32'h6000, 0, 3'b010, 1, 0, 1, 5'd2, 1);
        dmem_ready = 1;
        tick();
        dmem_ready = 0;
        rst = 1;
        tick();
        rst = 0;
        chk("rstw_req", dmem_req, 0);
        chk("rstw_wb", wb_valid, 0);
        chk("rstw_ready", ex_ready, 1);
        dmem_rvalid = 1; dmem_rdata = 32'h77777777;
        tick();
        dmem_rvalid = 0;
        chk("rstw_stray", wb_valid, 0);
        // Reset while in REQ drops the request on the same edge
        issue(32'h6100, 32'h1, 3'b010, 0, 1, 0, 5'd0, 0);
        rst = 1;
        tick();
        rst = 0;
        chk("rstr_req", dmem_req, 0);
        issue(32'h77, 0, 3'b000, 0, 0, 0, 5'd3, 1);
        chk("post_rst_wb", wb_valid, 1);
        chk("post_rst_addr", wb_address, 32'h77);

        // LH at odd address
        issue(32'h3001, 0, 3'b001, 1, 0, 1, 5'd3, 1);
`ifdef MISALIGN_TRAP_EN
        chk("mis_req", dmem_req, 0);
        chk("mis_wb_valid", wb_valid, 1);
        chk("mis_flag", wb_misalign, 1);
        chk("mis_rw", wb_reg_write, 0);
        chk("mis_addr", wb_address, 32'h3001);
`else
        chk("lh_req", dmem_req, 1);
        chk("lh_addr", dmem_addr, 32'h3000);
        chk("lh_be", dmem_be, 0);
        dmem_ready = 1; dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
        tick();
        dmem_ready = 0; dmem_rvalid = 0;
        chk("lh_wb_valid", wb_valid, 1);
        chk("lh_wb_addr", wb_address, 32'h3001);
        chk("lh_wb_rdata", wb_rdata, 32'hCAFEF00D);
        chk("lh_misalign", wb_misalign, 0);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
